// File: rtl/hamming_fifo_buf.sv
// hamming_fifo_buf: DEPTH-entry FIFO that stores each 8-bit word as a
// Hamming(12,8) codeword and checks/corrects it on the way out.
// Optional build macro: HAMMING_FIFO_SECDED_EN adds a 13th overall-parity
// bit, which gives SECDED behaviour (double errors flagged, not miscorrected).
// Codeword layout: positions 1..12 live at bits 0..11, parity at 1,2,4,8,
// data d0..d7 at 3,5,6,7,9,10,11,12. Bit 12 (SECDED only) is overall parity.
module hamming_fifo_buf #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic [12:0]              inj_mask,
    output logic                     full,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_corr,
    output logic                     err_uncorr,
    output logic [3:0]               err_syn,
    output logic [CNT_W-1:0]         corr_cnt,
    output logic                     ovf,
    output logic                     udf,
    input  logic                     clr_cnt
);

    localparam int AW = $clog2(DEPTH);
`ifdef HAMMING_FIFO_SECDED_EN
    localparam int W = 13;
`else
    localparam int W = 12;
`endif
    localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CORR_MAX = {CNT_W{1'b1}};

    // Build the 12-bit Hamming codeword (even parity per check bit).
    function automatic logic [11:0] hamming_enc(input logic [7:0] d);
        logic [11:0] c;
        c     = '0;
        c[2]  = d[0];
        c[4]  = d[1];
        c[5]  = d[2];
        c[6]  = d[3];
        c[8]  = d[4];
        c[9]  = d[5];
        c[10] = d[6];
        c[11] = d[7];
        c[0]  = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];   // positions 3,5,7,9,11
        c[1]  = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];   // positions 3,6,7,10,11
        c[3]  = c[4] ^ c[5] ^ c[6] ^ c[11];          // positions 5,6,7,12
        c[7]  = c[8] ^ c[9] ^ c[10] ^ c[11];         // positions 9,10,11,12
        return c;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             err_corr_q, err_corr_d;
    logic             err_uncorr_q, err_uncorr_d;
    logic [3:0]       err_syn_q, err_syn_d;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             wr_acc, rd_acc;
    logic [11:0]      wr_cw;
    logic [W-1:0]     wr_word;

    // Decode-path signals
    logic [W-1:0]     rd_raw;
    logic [11:0]      rd_fixed;
    logic [3:0]       dec_syn;
    logic             dec_flip;
    logic             dec_corr;
    logic             dec_uncorr;
    logic [7:0]       dec_data;

    // Flags come straight from the registered occupancy count.
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    // ------------------------------------------------------------------
    // Write-side encode plus error injection
    // ------------------------------------------------------------------
    assign wr_cw = hamming_enc(wr_data);
`ifdef HAMMING_FIFO_SECDED_EN
    assign wr_word = {^wr_cw, wr_cw} ^ inj_mask;
`else
    // Overall-parity injection has no storage bit in the 12-bit build.
    logic unused_inj;
    assign unused_inj = inj_mask[12];
    assign wr_word    = wr_cw ^ inj_mask[11:0];
`endif

    // Storage array; contents are don't-care after reset so it has none.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_word;
    end

    // ------------------------------------------------------------------
    // Read-side syndrome, classification and correction
    // ------------------------------------------------------------------
    assign rd_raw = mem_q[rd_ptr_q];

    // Compute syndrome, decide correct/flag, and extract the data bits.
    always_comb begin
        dec_syn    = '0;
        dec_flip   = 1'b0;
        dec_corr   = 1'b0;
        dec_uncorr = 1'b0;
        for (int p = 1; p <= 12; p++) begin
            if (rd_raw[p-1]) dec_syn = dec_syn ^ 4'(p);
        end
`ifdef HAMMING_FIFO_SECDED_EN
        if (^rd_raw) begin
            // Odd overall parity: one bit flipped somewhere.
            if (dec_syn == 4'd0) begin
                dec_corr = 1'b1;               // only the parity bit itself
            end else if (dec_syn <= 4'd12) begin
                dec_flip = 1'b1;
                dec_corr = 1'b1;
            end else begin
                dec_uncorr = 1'b1;             // points outside the word
            end
        end else if (dec_syn != 4'd0) begin
            dec_uncorr = 1'b1;                 // even parity, nonzero syndrome: double error
        end
`else
        if (dec_syn != 4'd0) begin
            if (dec_syn <= 4'd12) begin
                dec_flip = 1'b1;
                dec_corr = 1'b1;
            end else begin
                dec_uncorr = 1'b1;
            end
        end
`endif
        rd_fixed = rd_raw[11:0];
        if (dec_flip) rd_fixed[dec_syn - 4'd1] = ~rd_fixed[dec_syn - 4'd1];
        dec_data = {rd_fixed[11], rd_fixed[10], rd_fixed[9], rd_fixed[8],
                    rd_fixed[6],  rd_fixed[5],  rd_fixed[4], rd_fixed[2]};
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Pointer and occupancy updates; simultaneous accept leaves count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Read result registers: data/syndrome hold, error strobes pulse.
    always_comb begin
        rd_data_d    = rd_data_q;
        err_syn_d    = err_syn_q;
        rd_valid_d   = rd_acc;
        err_corr_d   = 1'b0;
        err_uncorr_d = 1'b0;
        if (rd_acc) begin
            rd_data_d    = dec_data;
            err_syn_d    = dec_syn;
            err_corr_d   = dec_corr;
            err_uncorr_d = dec_uncorr;
        end
    end

    // Statistics: clear wins over a same-cycle increment or flag set.
    always_comb begin
        corr_cnt_d = corr_cnt_q;
        ovf_d      = ovf_q | (wr_en & full);
        udf_d      = udf_q | (rd_en & empty);
        if (rd_acc && dec_corr && corr_cnt_q != CORR_MAX) corr_cnt_d = corr_cnt_q + 1'b1;
        if (clr_cnt) begin
            corr_cnt_d = '0;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
        end
    end

    // Register update with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            err_corr_q   <= 1'b0;
            err_uncorr_q <= 1'b0;
            err_syn_q    <= '0;
            corr_cnt_q   <= '0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            err_corr_q   <= err_corr_d;
            err_uncorr_q <= err_uncorr_d;
            err_syn_q    <= err_syn_d;
            corr_cnt_q   <= corr_cnt_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
        end
    end

    assign count      = count_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign err_corr   = err_corr_q;
    assign err_uncorr = err_uncorr_q;
    assign err_syn    = err_syn_q;
    assign corr_cnt   = corr_cnt_q;
    assign ovf        = ovf_q;
    assign udf        = udf_q;

endmodule

// File: tb/tb_hamming_fifo_buf.sv
// Bench for hamming_fifo_buf: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_hamming_fifo_buf;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en, clr_cnt;
    logic [7:0]  wr_data;
    logic [12:0] inj_mask;
    logic        full, empty, rd_valid, err_corr, err_uncorr, ovf, udf;
    logic [7:0]  rd_data;
    logic [3:0]  err_syn;
    logic [3:0]  count;
    logic [7:0]  corr_cnt;

    int vec = 0;
    int err = 0;

    typedef struct {
        logic [7:0] data;
        logic       corr;
        logic       uncorr;
        logic [3:0] syn;
    } exp_t;

    hamming_fifo_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .inj_mask(inj_mask), .full(full), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .empty(empty), .count(count),
        .err_corr(err_corr), .err_uncorr(err_uncorr), .err_syn(err_syn),
        .corr_cnt(corr_cnt), .ovf(ovf), .udf(udf), .clr_cnt(clr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Position of data bit i in the codeword (1-based).
    function automatic int dpos(input int i);
        case (i)
            0: return 3;  1: return 5;  2: return 6;  3: return 7;
            4: return 9;  5: return 10; 6: return 11; default: return 12;
        endcase
    endfunction

    // Reference encoder straight from the parity-coverage definition.
    function automatic logic [11:0] ref_enc(input logic [7:0] d);
        logic [11:0] cw;
        logic        p;
        cw = '0;
        for (int i = 0; i < 8; i++) cw[dpos(i)-1] = d[i];
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int pos = 1; pos <= 12; pos++) if (pos[k]) p = p ^ cw[pos-1];
            cw[(1 << k) - 1] = p;
        end
        return cw;
    endfunction

    // Expected read result: a valid codeword has zero syndrome, so the
    // syndrome seen on read is just that of the injected error pattern.
    function automatic exp_t model_entry(input logic [7:0] d, input logic [12:0] m);
        exp_t        e;
        logic [11:0] cw;
        logic [3:0]  s;
        logic        flip;
        cw = ref_enc(d) ^ m[11:0];
        s  = '0;
        for (int p = 1; p <= 12; p++) if (m[p-1]) s = s ^ 4'(p);
        e.corr = 1'b0; e.uncorr = 1'b0; flip = 1'b0;
`ifdef HAMMING_FIFO_SECDED_EN
        if (^m) begin
            if (s == 0) e.corr = 1'b1;
            else if (s <= 12) begin e.corr = 1'b1; flip = 1'b1; end
            else e.uncorr = 1'b1;
        end else if (s != 0) e.uncorr = 1'b1;
`else
        if (s != 0) begin
            if (s <= 12) begin e.corr = 1'b1; flip = 1'b1; end
            else e.uncorr = 1'b1;
        end
`endif
        if (flip) cw[s-1] = ~cw[s-1];
        for (int i = 0; i < 8; i++) e.data[i] = cw[dpos(i)-1];
        e.syn = s;
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; rd_en = 0; clr_cnt = 0; inj_mask = '0; wr_data = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        cyc();
        rst = 1;
        cyc();
    endtask

    task automatic write1(input logic [7:0] d, input logic [12:0] m);
        wr_en = 1; wr_data = d; inj_mask = m;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        #3;
        vec++; if ({count, empty, full} !== {4'd0, 1'b1, 1'b0}) begin err++;
            $display("FAIL reset_flags: got count=%0d empty=%b full=%b want 0/1/0", count, empty, full); end
        vec++; if ({rd_data, rd_valid, err_corr, err_uncorr, err_syn} !== 15'd0) begin err++;
            $display("FAIL reset_read: got data=%h v=%b c=%b u=%b syn=%0d want all zero", rd_data, rd_valid, err_corr, err_uncorr, err_syn); end
        vec++; if ({corr_cnt, ovf, udf} !== 10'd0) begin err++;
            $display("FAIL reset_stats: got corr_cnt=%0d ovf=%b udf=%b want 0", corr_cnt, ovf, udf); end
        cyc();
        rst = 1;
        cyc();
    endtask

    task automatic test_basic();
        write1(8'hA5, 13'h0);
        rd_en = 1;
        cyc();
        idle();
        vec++; if ({rd_valid, rd_data, err_syn, err_corr, corr_cnt} !== {1'b1, 8'hA5, 4'd0, 1'b0, 8'd0}) begin err++;
            $display("FAIL basic_read: got v=%b data=%h syn=%0d corr=%b cnt=%0d want 1/a5/0/0/0", rd_valid, rd_data, err_syn, err_corr, corr_cnt); end
        cyc();
        vec++; if ({rd_valid, rd_data} !== {1'b0, 8'hA5}) begin err++;
            $display("FAIL basic_pulse: got v=%b data=%h want v=0 data held a5", rd_valid, rd_data); end
    endtask

    task automatic test_single_corr();
        write1(8'h3C, 13'h010);
        rd_en = 1;
        cyc();
        idle();
        vec++; if ({rd_valid, rd_data, err_corr, err_uncorr, err_syn, corr_cnt} !== {1'b1, 8'h3C, 1'b1, 1'b0, 4'd5, 8'd1}) begin err++;
            $display("FAIL single_corr: got v=%b data=%h c=%b u=%b syn=%0d cnt=%0d want 1/3c/1/0/5/1", rd_valid, rd_data, err_corr, err_uncorr, err_syn, corr_cnt); end
        cyc();
        vec++; if ({err_corr, err_syn} !== {1'b0, 4'd5}) begin err++;
            $display("FAIL syn_hold: got corr=%b syn=%0d want 0/5", err_corr, err_syn); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) write1(8'(i), 13'h0);
        vec++; if ({full, empty, count} !== {1'b1, 1'b0, 4'd8}) begin err++;
            $display("FAIL fill_full: got full=%b empty=%b count=%0d want 1/0/8", full, empty, count); end
        write1(8'hFF, 13'h0);
        vec++; if ({ovf, count} !== {1'b1, 4'd8}) begin err++;
            $display("FAIL fill_ovf: got ovf=%b count=%0d want 1/8", ovf, count); end
        for (int i = 1; i <= DEPTH; i++) begin
            rd_en = 1;
            cyc();
            vec++; if ({rd_valid, rd_data} !== {1'b1, 8'(i)}) begin err++;
                $display("FAIL fill_order[%0d]: got v=%b data=%h want 1/%h", i, rd_valid, rd_data, 8'(i)); end
        end
        idle();
        vec++; if ({empty, count} !== {1'b1, 4'd0}) begin err++;
            $display("FAIL drain_empty: got empty=%b count=%0d want 1/0", empty, count); end
        rd_en = 1;
        cyc();
        idle();
        vec++; if ({udf, rd_valid} !== {1'b1, 1'b0}) begin err++;
            $display("FAIL udf: got udf=%b v=%b want 1/0", udf, rd_valid); end
        clr_cnt = 1;
        cyc();
        idle();
        vec++; if ({ovf, udf, corr_cnt} !== {1'b0, 1'b0, 8'd0}) begin err++;
            $display("FAIL clr_cnt: got ovf=%b udf=%b cnt=%0d want 0/0/0", ovf, udf, corr_cnt); end
    endtask

    task automatic test_simul();
        write1(8'h11, 13'h0);
        wr_en = 1; wr_data = 8'h22; rd_en = 1;
        cyc();
        idle();
        vec++; if ({count, rd_valid, rd_data} !== {4'd1, 1'b1, 8'h11}) begin err++;
            $display("FAIL simul_rw: got count=%0d v=%b data=%h want 1/1/11", count, rd_valid, rd_data); end
        rd_en = 1;
        cyc();
        idle();
        vec++; if ({count, rd_valid, rd_data} !== {4'd0, 1'b1, 8'h22}) begin err++;
            $display("FAIL simul_remain: got count=%0d v=%b data=%h want 0/1/22", count, rd_valid, rd_data); end
        // Empty: write only, no fall-through.
        wr_en = 1; wr_data = 8'h33; rd_en = 1;
        cyc();
        idle();
        vec++; if ({count, rd_valid, udf} !== {4'd1, 1'b0, 1'b1}) begin err++;
            $display("FAIL simul_empty: got count=%0d v=%b udf=%b want 1/0/1", count, rd_valid, udf); end
        clr_cnt = 1;
        cyc();
        idle();
    endtask

    task automatic test_reset_mid();
        write1(8'h44, 13'h0);
        write1(8'h55, 13'h0);
        write1(8'h66, 13'h0);
        #3 rst = 0;
        #1;
        vec++; if ({count, empty, full, rd_data} !== {4'd0, 1'b1, 1'b0, 8'h00}) begin err++;
            $display("FAIL reset_mid: got count=%0d empty=%b full=%b data=%h want 0/1/0/00", count, empty, full, rd_data); end
        @(negedge clk);
        rst = 1;
        cyc();
        rd_en = 1;
        cyc();
        idle();
        vec++; if ({udf, rd_valid} !== {1'b1, 1'b0}) begin err++;
            $display("FAIL reset_mid_udf: got udf=%b v=%b want 1/0", udf, rd_valid); end
    endtask

    task automatic test_multi_err();
        do_reset();
`ifdef HAMMING_FIFO_SECDED_EN
        write1(8'h5A, 13'h003);
        rd_en = 1; cyc(); idle();
        vec++; if ({err_uncorr, err_corr, corr_cnt, rd_data} !== {1'b1, 1'b0, 8'd0, 8'h5A}) begin err++;
            $display("FAIL secded_double: got u=%b c=%b cnt=%0d data=%h want 1/0/0/5a", err_uncorr, err_corr, corr_cnt, rd_data); end
        write1(8'h5A, 13'h1000);
        rd_en = 1; cyc(); idle();
        vec++; if ({rd_data, err_corr, err_uncorr, err_syn, corr_cnt} !== {8'h5A, 1'b1, 1'b0, 4'd0, 8'd1}) begin err++;
            $display("FAIL secded_par: got data=%h c=%b u=%b syn=%0d cnt=%0d want 5a/1/0/0/1", rd_data, err_corr, err_uncorr, err_syn, corr_cnt); end
`else
        // Positions 1 and 12 give syndrome 13: flagged, data raw (d7 flipped).
        write1(8'h5A, 13'h801);
        rd_en = 1; cyc(); idle();
        vec++; if ({rd_data, err_uncorr, err_corr, err_syn, corr_cnt} !== {8'hDA, 1'b1, 1'b0, 4'd13, 8'd0}) begin err++;
            $display("FAIL uncorr_13: got data=%h u=%b c=%b syn=%0d cnt=%0d want da/1/0/13/0", rd_data, err_uncorr, err_corr, err_syn, corr_cnt); end
`endif
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        logic        rd_acc, wr_acc, exp_ovf, exp_udf;
        int          exp_cnt;
        logic [12:0] m;
        int          b0, b1;
        do_reset();
        exp_ovf = 0; exp_udf = 0; exp_cnt = 0;
        for (int n = 0; n < 600; n++) begin
            wr_en   = ($urandom_range(0, 99) < 55);
            rd_en   = ($urandom_range(0, 99) < 45);
            clr_cnt = ($urandom_range(0, 99) < 3);
            wr_data = 8'($urandom);
            case ($urandom_range(0, 3))
                0: m = '0;
                1: m = 13'(1) << $urandom_range(0, 11);
                2: begin
                    b0 = $urandom_range(0, 12);
                    b1 = (b0 + 1 + $urandom_range(0, 11)) % 13;
                    m  = (13'(1) << b0) | (13'(1) << b1);
                end
                default: m = 13'h1000;
            endcase
            inj_mask = m;
            wr_acc = wr_en && (q.size() != DEPTH);
            rd_acc = rd_en && (q.size() != 0);
            if (wr_en && q.size() == DEPTH) exp_ovf = 1;
            if (rd_en && q.size() == 0) exp_udf = 1;
            e = '{data: 8'h0, corr: 1'b0, uncorr: 1'b0, syn: 4'h0};
            if (rd_acc) begin
                e = q.pop_front();
                if (e.corr && exp_cnt < 255) exp_cnt++;
            end
            if (clr_cnt) begin exp_cnt = 0; exp_ovf = 0; exp_udf = 0; end
            if (wr_acc) q.push_back(model_entry(wr_data, m));
            cyc();
            vec++; if (rd_valid !== rd_acc) begin err++;
                $display("FAIL rnd_valid[%0d]: got %b want %b", n, rd_valid, rd_acc); end
            if (rd_acc) begin
                vec++; if ({rd_data, err_corr, err_uncorr, err_syn} !== {e.data, e.corr, e.uncorr, e.syn}) begin err++;
                    $display("FAIL rnd_read[%0d]: got data=%h c=%b u=%b syn=%0d want %h/%b/%b/%0d",
                             n, rd_data, err_corr, err_uncorr, err_syn, e.data, e.corr, e.uncorr, e.syn); end
            end
            vec++; if ({count, full, empty} !== {4'(q.size()), q.size() == DEPTH, q.size() == 0}) begin err++;
                $display("FAIL rnd_occ[%0d]: got count=%0d full=%b empty=%b want count=%0d", n, count, full, empty, q.size()); end
            vec++; if ({corr_cnt, ovf, udf} !== {8'(exp_cnt), exp_ovf, exp_udf}) begin err++;
                $display("FAIL rnd_stats[%0d]: got cnt=%0d ovf=%b udf=%b want %0d/%b/%b", n, corr_cnt, ovf, udf, exp_cnt, exp_ovf, exp_udf); end
        end
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        #2;
        test_reset();
        test_basic();
        test_single_corr();
        test_fill();
        test_simul();
        test_reset_mid();
        test_multi_err();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/hamming_fifo_buf.md
Name: hamming_fifo_buf

Overview:
- Downstream consumer of the Hamming-protected 8-bit universal shift register.
- Captures the register's parallel_out words into a DEPTH-entry FIFO.
- Each word is stored as a Hamming(12,8) codeword, then checked and corrected on read.
- Reports corrected and uncorrectable errors and keeps a saturating correction counter.
- Provides a write-side error-injection mask so benches can exercise the correction path without force/release.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- CNT_W, 8, width of the corrected-error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- wr_en  in  1  write request.
- wr_data  in  8  word to store; driven from the register's parallel_out.
- inj_mask  in  13  XORed into the encoded codeword at write. Bits 11:0 map to positions 1..12. Bit 12 maps to overall parity.
- full  out  1  FIFO full.
- rd_en  in  1  read request.
- rd_data  out  8  corrected read word.
- rd_valid  out  1  rd_data valid; one-cycle pulse.
- empty  out  1  FIFO empty.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- err_corr  out  1  single-bit error corrected on this read; pulse aligned with rd_valid.
- err_uncorr  out  1  uncorrectable error on this read; pulse aligned with rd_valid.
- err_syn  out  4  syndrome of the last read; held until the next read.
- corr_cnt  out  CNT_W  corrected-error count; saturates at all-ones.
- ovf  out  1  sticky flag: a write was attempted while full.
- udf  out  1  sticky flag: a read was attempted while empty.
- clr_cnt  in  1  synchronous clear of corr_cnt, ovf and udf.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers reset to 0; count=0, empty=1, full=0.
  - rd_data=0, rd_valid=0, err_corr=0, err_uncorr=0, err_syn=0.
  - corr_cnt=0, ovf=0, udf=0.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards all stored entries. The first read after reset-release sees empty.
- Encoding:
  - Positions 1..12 are stored at bits 0..11.
  - Parity bits at positions 1, 2, 4, 8.
  - Data bits d0..d7 at positions 3, 5, 6, 7, 9, 10, 11, 12.
  - Parity bit p_k is the even-parity XOR of every position whose index has bit k set.
  - The stored word is codeword XOR inj_mask[11:0].
- Write: accepted on a clk rising edge when wr_en=1 and full=0.
  - On acceptance, write the entry and increment wr_ptr; it wraps modulo DEPTH.
  - wr_en=1 while full: no write; ovf is set.
- Read: accepted on a clk rising edge when rd_en=1 and empty=0.
  - The entry is decoded and registered the same edge; latency is 1 cycle.
  - rd_data, err_syn and the error pulses are valid in the cycle following that edge, with rd_valid=1 for that single cycle.
  - rd_ptr wraps modulo DEPTH.
  - rd_en=1 while empty: no read, rd_valid=0, udf is set.
- Decode:
  - Syndrome = XOR of the indices of all set bits.
  - Syndrome 0: no error.
  - Syndrome 1..12: flip that position, set err_corr, increment corr_cnt (saturating).
  - Syndrome 13..15: err_uncorr=1; rd_data carries the raw data bits uncorrected.
- Simultaneous read and write in the same cycle:
  - Both are accepted when individually legal; count is unchanged.
  - When empty, only the write occurs; there is no fall-through.
  - When full, only the read occurs; the write is dropped and ovf is set.
- Flags:
  - full = (count==DEPTH); empty = (count==0).
  - Both are derived from the registered count, with no combinational path from wr_en/rd_en.
- clr_cnt:
  - Has priority over a same-cycle increment of corr_cnt.
  - Also has priority over a same-cycle set of ovf/udf.

Optional Feature:
- Macro HAMMING_FIFO_SECDED_EN.
- When defined:
  - Storage is 13 bits; bit 12 holds overall even parity of bits 0..11, XOR inj_mask[12].
  - Overall mismatch with syndrome≠0: correct the flagged position, err_corr=1.
  - Overall mismatch with syndrome=0: the parity bit itself is in error; data is good, err_corr=1.
  - Overall match with syndrome≠0: double error; err_uncorr=1, no correction, corr_cnt unchanged.
- When undefined:
  - Storage is 12 bits and inj_mask[12] is ignored.
  - Double errors miscorrect silently, except for syndromes 13..15.

Test Plan:
- Reset, write 0xA5 with inj_mask=0, then read -> rd_data=0xA5, rd_valid pulse one cycle after the rd edge, err_syn=0, err_corr=0, corr_cnt=0.
- Write 0x3C with inj_mask=0x010 (position 5), then read -> rd_data=0x3C, err_corr=1, err_syn=5, corr_cnt=1.
- Write 0x01..0x08 -> full=1, count=8. A 9th write of 0xFF -> dropped, ovf=1. Then 8 reads -> 0x01..0x08 in order, empty=1. A 9th read -> udf=1, rd_valid=0. clr_cnt -> ovf=0, udf=0.
- With count=1, assert wr_en and rd_en together -> count stays 1; the old word is returned and the new word remains.
- After 3 writes, pulse rst low mid-cycle -> count=0, empty=1, rd_data=0 immediately (asynchronously); subsequent read -> udf=1.
- With HAMMING_FIFO_SECDED_EN: inj_mask=0x003 on 0x5A -> err_uncorr=1, err_corr=0, corr_cnt unchanged. inj_mask=0x1000 -> rd_data=0x5A, err_corr=1, err_syn=0.
